block_ram_dual_port_asym_pipe: RTL and testbench
================================================

Name: block_ram_dual_port_asym_pipe

Overview:
Single-clock true dual-port block RAM with byte-lane writes, used as shared scratch and frame memory between a narrow engine (port A) and a wide engine (port B). It extends the symmetric dual-port RAM in four ways:
- asymmetric port widths (port B is a power-of-two multiple of port A);
- a selectable same-port read-during-write mode;
- an optional output pipeline register with valid flags;
- deterministic write-collision arbitration with a collision pulse and a saturating collision counter.

Parameters:
DATA_BYTES, 2, byte columns per port-A word
PARITY_BITS, 0, extra bits per column (0 or 1); COL = 8+PARITY_BITS; WA = DATA_BYTES*COL
ADDR_WIDTH, 10, port-A address width; depth = 2^ADDR_WIDTH A-words
B_RATIO_LOG2, 1, port B width = WA*R with R = 2^B_RATIO_LOG2 (0..2); AWB = ADDR_WIDTH-B_RATIO_LOG2
WRITE_MODE, 0, same-port read-during-write: 0 read-first, 1 write-first, 2 no-change
OUTPUT_REG, 0, 0: read latency 1; 1: read latency 2
MEM_INIT_VAL, all zeros, WA-bit initial value of every A-word
DATA_OUT_RESET_VAL, MEM_INIT_VAL, WA-bit output reset value; replicated R times on dataOutB
CNT_WIDTH, 16, collision counter width

Ports:
clockA  in  1  sole clock for both ports and all state
resetB  in  1  synchronous active-high reset
enableA  in  1  port-A access request
writeEnableA  in  DATA_BYTES  port-A byte-lane write enables
addressA  in  ADDR_WIDTH  port-A A-word address
dataInA  in  WA  port-A write data
dataOutA  out  WA  port-A read data
validA  out  1  dataOutA updated this cycle
enableB  in  1  port-B access request
writeEnableB  in  DATA_BYTES*R  port-B byte-lane write enables
addressB  in  AWB  port-B wide-word address
dataInB  in  WA*R  port-B write data
dataOutB  out  WA*R  port-B read data
validB  out  1  dataOutB updated this cycle
collision  out  1  one-cycle pulse on an arbitrated write collision
collisionCount  out  CNT_WIDTH  saturating count of collision cycles

Behaviour:
- Clocking and reset:
  - All state changes on rising clockA.
  - Reset is "resetB, synchronous, active-high; clock clockA".
  - On reset: dataOutA = DATA_OUT_RESET_VAL, dataOutB = R copies of DATA_OUT_RESET_VAL, validA = validB = 0, collision = 0, collisionCount = 0, pipeline stages cleared.
  - While resetB is high, all RAM writes are suppressed and new reads are dropped. RAM contents are never cleared by reset; they hold MEM_INIT_VAL after initialisation.
- Wide-port mapping: lane k of port B (bits [(k+1)*WA-1 : k*WA]) maps to A-word addressB*R+k. writeEnableB[k*DATA_BYTES+j] enables byte j of lane k.
- Access classes:
  - A cycle with enableX=1 and writeEnableX=0 is a read.
  - A cycle with enableX=1 and any writeEnableX bit set is a write.
  - enableX=0 means no access on that port.
- Read data per WRITE_MODE:
  - 0 (read-first): a write cycle also reads, returning the old contents.
  - 1 (write-first): a write cycle also reads, returning the new bytes in enabled lanes and old bytes elsewhere.
  - 2 (no-change): a write cycle produces no read; dataOut holds and valid stays 0.
- Cross-port reads: reading an A-word the other port writes in the same cycle always returns the old contents.
- Latency:
  - A read accepted at cycle N updates dataOutX and pulses validX at N+1 (OUTPUT_REG=0) or N+2 (OUTPUT_REG=1).
  - The pipeline is fully pipelined: one access per cycle per port, no stalls.
  - dataOutX holds its value when validX=0.
- Collision:
  - Occurs when both ports write the same A-word in the same cycle and at least one byte lane is enabled by both.
  - Port B wins on the overlapping bytes; non-overlapping enabled bytes from each port are written normally.
  - collision pulses 1 at N+1. collisionCount increments at N+1 and saturates at all-ones.
  - Overlapping addresses with disjoint byte enables are not a collision.
- Reset mid-operation: reads already in flight are discarded, so no valid pulse appears for them after reset is released. Accesses resume on the first cycle with resetB low.
- Address wrap is not applicable: all addresses are in range by construction.

Test Plan:
- Reset: hold resetB 2 cycles with enableA=1, writeEnableA=2'b11, addressA=5, dataInA=16'hBEEF; release, then read addressA=5 -> dataOutA=16'h0000 (write suppressed), validA=0 during reset.
- Asymmetric mapping (R=2, OUTPUT_REG=0): A writes 16'h1111 to address 6 and 16'h2222 to address 7; B reads addressB=3 -> dataOutB=32'h2222_1111 with validB one cycle later.
- Write modes: address 4 holds 16'hAAAA; A writes 16'h5555 to it -> next cycle dataOutA=16'hAAAA (mode 0), 16'h5555 (mode 1), prior value held with validA=0 (mode 2).
- Collision: A writes 16'h1234 (writeEnableA=2'b11) to address 8 while B writes lane 0 16'hABCD (writeEnableB=4'b0001) to addressB=4 -> address 8 = 16'h12CD, collision=1 for one cycle, collisionCount=1; disjoint enables give collision=0.
- Pipeline (OUTPUT_REG=1): back-to-back A reads of addresses 0,1,2 -> validA high at N+2..N+4 with data in order; assert resetB at N+3 -> no validA after release until a new read.
- Saturation (CNT_WIDTH=2): 5 colliding cycles -> collisionCount sequence 1,2,3,3,3.

Source files
------------

// File: rtl/block_ram_dual_port_asym_pipe.sv
// ---------------------------------------------------------------------------
// block_ram_dual_port_asym_pipe
//
// Single-clock true dual-port block RAM with byte-lane writes, shared between
// a narrow engine on port A and a wide engine on port B.
//
//   * Port B is R = 2**B_RATIO_LOG2 A-words wide. Lane k of a B word is the
//     A-word at addressB*R + k.
//   * Same-port read-during-write behaviour is chosen by WRITE_MODE
//     (0 read-first, 1 write-first, 2 no-change).
//   * Read latency is 1 (OUTPUT_REG=0) or 2 (OUTPUT_REG=1), fully pipelined.
//   * Both ports writing the same byte of the same A-word is a collision:
//     port B wins that byte, a one-cycle pulse is raised and a saturating
//     counter is bumped.
//
// Ports
//   clockA          sole clock
//   resetB          synchronous, active-high; suppresses all accesses
//   enableA         port-A access request
//   writeEnableA    port-A byte-lane write enables (any set => write)
//   addressA        port-A A-word address
//   dataInA         port-A write data
//   dataOutA        port-A read data (holds when validA=0)
//   validA          dataOutA updated this cycle
//   enableB         port-B access request
//   writeEnableB    port-B byte-lane write enables, lane-major
//   addressB        port-B wide-word address
//   dataInB         port-B write data
//   dataOutB        port-B read data (holds when validB=0)
//   validB          dataOutB updated this cycle
//   collision       one-cycle pulse for an arbitrated write collision
//   collisionCount  saturating count of collision cycles
// ---------------------------------------------------------------------------
module block_ram_dual_port_asym_pipe #(
  parameter int DATA_BYTES   = 2,
  parameter int PARITY_BITS  = 0,
  parameter int ADDR_WIDTH   = 10,
  parameter int B_RATIO_LOG2 = 1,
  parameter int WRITE_MODE   = 0,
  parameter int OUTPUT_REG   = 0,
  parameter logic [DATA_BYTES*(8+PARITY_BITS)-1:0] MEM_INIT_VAL       = '0,
  parameter logic [DATA_BYTES*(8+PARITY_BITS)-1:0] DATA_OUT_RESET_VAL = MEM_INIT_VAL,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                                     clockA,
  input  logic                                                     resetB,
  input  logic                                                     enableA,
  input  logic [DATA_BYTES-1:0]                                    writeEnableA,
  input  logic [ADDR_WIDTH-1:0]                                    addressA,
  input  logic [DATA_BYTES*(8+PARITY_BITS)-1:0]                    dataInA,
  output logic [DATA_BYTES*(8+PARITY_BITS)-1:0]                    dataOutA,
  output logic                                                     validA,
  input  logic                                                     enableB,
  input  logic [DATA_BYTES*(2**B_RATIO_LOG2)-1:0]                  writeEnableB,
  input  logic [ADDR_WIDTH-B_RATIO_LOG2-1:0]                       addressB,
  input  logic [DATA_BYTES*(8+PARITY_BITS)*(2**B_RATIO_LOG2)-1:0]  dataInB,
  output logic [DATA_BYTES*(8+PARITY_BITS)*(2**B_RATIO_LOG2)-1:0]  dataOutB,
  output logic                                                     validB,
  output logic                                                     collision,
  output logic [CNT_WIDTH-1:0]                                     collisionCount
);

  localparam int COL   = 8 + PARITY_BITS;
  localparam int WA    = DATA_BYTES * COL;
  localparam int R     = 2 ** B_RATIO_LOG2;
  localparam int WB    = WA * R;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [WB-1:0] B_RESET_VAL = {R{DATA_OUT_RESET_VAL}};

  // Replace the byte columns selected by we with the matching columns of din.
  function automatic logic [WA-1:0] byte_merge(input logic [WA-1:0]         base,
                                               input logic [DATA_BYTES-1:0] we,
                                               input logic [WA-1:0]         din);
    logic [WA-1:0] r;
    r = base;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (we[j]) r[j*COL +: COL] = din[j*COL +: COL];
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WA-1:0] mem [DEPTH] = '{default: MEM_INIT_VAL};

  logic [DATA_BYTES-1:0] we_a;
  logic                  wr_a;
  logic                  rd_a;
  logic                  wr_b;
  logic                  rd_b;
  logic [ADDR_WIDTH-1:0] lane_addr [R];
  logic [DATA_BYTES-1:0] lane_we   [R];
  logic [WA-1:0]         lane_din  [R];
  logic [DATA_BYTES-1:0] a_bhit;
  logic [WA-1:0]         a_bdat;
  logic [WA-1:0]         a_old;
  logic [WA-1:0]         a_wf;
  logic [WB-1:0]         b_old;
  logic [WB-1:0]         b_wf;
  logic                  coll;

  always_comb begin
    we_a   = writeEnableA & {DATA_BYTES{enableA & ~resetB}};
    wr_a   = |we_a;
    wr_b   = enableB & ~resetB & (|writeEnableB);
    rd_a   = enableA & ~resetB & (~wr_a | (WRITE_MODE != 2));
    rd_b   = enableB & ~resetB & (~wr_b | (WRITE_MODE != 2));
    a_old  = mem[addressA];
    a_bhit = '0;
    a_bdat = '0;
    b_old  = '0;
    b_wf   = '0;
    for (int k = 0; k < R; k++) begin
      lane_addr[k] = (ADDR_WIDTH'(addressB) << B_RATIO_LOG2) | ADDR_WIDTH'(k);
      lane_we[k]   = writeEnableB[k*DATA_BYTES +: DATA_BYTES] & {DATA_BYTES{enableB & ~resetB}};
      lane_din[k]  = dataInB[k*WA +: WA];
      b_old[k*WA +: WA] = mem[lane_addr[k]];
      b_wf[k*WA +: WA]  = byte_merge(mem[lane_addr[k]], lane_we[k], lane_din[k]);
      // At most one lane can alias port A's word; remember which bytes it writes.
      if (lane_addr[k] == addressA) begin
        a_bhit = lane_we[k];
        a_bdat = lane_din[k];
      end
    end
    coll = |(we_a & a_bhit);
    // Write-first on A shows what actually lands in the RAM, so bytes that
    // port B overrides read back as port B's data.
    a_wf = byte_merge(byte_merge(a_old, we_a, dataInA), we_a & a_bhit, a_bdat);
  end

  // Port B's writes are issued after port A's in the same process, so the
  // later non-blocking assignment gives port B the overlapping bytes.
  always_ff @(posedge clockA) begin
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (we_a[j]) mem[addressA][j*COL +: COL] <= dataInA[j*COL +: COL];
    end
    for (int k = 0; k < R; k++) begin
      for (int j = 0; j < DATA_BYTES; j++) begin
        if (lane_we[k][j]) mem[lane_addr[k]][j*COL +: COL] <= lane_din[k][j*COL +: COL];
      end
    end
  end

  // ---- stage p0: RAM read register, collision flag and counter ----
  logic [WA-1:0]        rd_a_p0;
  logic [WB-1:0]        rd_b_p0;
  logic                 vld_a_p0;
  logic                 vld_b_p0;
  logic                 coll_p0;
  logic [CNT_WIDTH-1:0] cnt_p0;

  always_ff @(posedge clockA) begin
    if (resetB) begin
      rd_a_p0  <= DATA_OUT_RESET_VAL;
      rd_b_p0  <= B_RESET_VAL;
      vld_a_p0 <= 1'b0;
      vld_b_p0 <= 1'b0;
      coll_p0  <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      vld_a_p0 <= rd_a;
      vld_b_p0 <= rd_b;
      coll_p0  <= coll;
      if (coll) cnt_p0 <= sat_inc(cnt_p0);
      if (rd_a) rd_a_p0 <= (WRITE_MODE == 1 && wr_a) ? a_wf : a_old;
      if (rd_b) rd_b_p0 <= (WRITE_MODE == 1 && wr_b) ? b_wf : b_old;
    end
  end

  assign collision      = coll_p0;
  assign collisionCount = cnt_p0;

  // ---- stage p1: optional output register ----
  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [WA-1:0] rd_a_p1;
      logic [WB-1:0] rd_b_p1;
      logic          vld_a_p1;
      logic          vld_b_p1;

      always_ff @(posedge clockA) begin
        if (resetB) begin
          rd_a_p1  <= DATA_OUT_RESET_VAL;
          rd_b_p1  <= B_RESET_VAL;
          vld_a_p1 <= 1'b0;
          vld_b_p1 <= 1'b0;
        end else begin
          vld_a_p1 <= vld_a_p0;
          vld_b_p1 <= vld_b_p0;
          if (vld_a_p0) rd_a_p1 <= rd_a_p0;
          if (vld_b_p0) rd_b_p1 <= rd_b_p0;
        end
      end

      assign dataOutA = rd_a_p1;
      assign validA   = vld_a_p1;
      assign dataOutB = rd_b_p1;
      assign validB   = vld_b_p1;
    end else begin : g_noreg
      assign dataOutA = rd_a_p0;
      assign validA   = vld_a_p0;
      assign dataOutB = rd_b_p0;
      assign validB   = vld_b_p0;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_dual_port_asym_pipe.sv
// ---------------------------------------------------------------------------
// tb_block_ram_dual_port_asym_pipe
//
// Three RAM instances share one stimulus stream:
//   d0: read-first,  latency 1, 16-bit counter
//   d1: write-first, latency 2,  2-bit counter
//   d2: no-change,   latency 1, 16-bit counter, non-zero output reset value
// A word-level memory model predicts every output of every instance on every
// cycle; a handful of hand-computed constants cross-check the key scenarios.
// ---------------------------------------------------------------------------
module tb_block_ram_dual_port_asym_pipe;

  logic        clk;
  logic        rst;
  logic        ena, enb;
  logic [1:0]  wea;
  logic [3:0]  web;
  logic [3:0]  adda;
  logic [2:0]  addb;
  logic [15:0] dina;
  logic [31:0] dinb;

  logic [15:0] oa0, oa1, oa2;
  logic [31:0] ob0, ob1, ob2;
  logic        va0, va1, va2, vb0, vb1, vb2, co0, co1, co2;
  logic [15:0] cn0, cn2;
  logic [1:0]  cn1;

  block_ram_dual_port_asym_pipe #(.ADDR_WIDTH(4), .B_RATIO_LOG2(1), .WRITE_MODE(0),
    .OUTPUT_REG(0), .CNT_WIDTH(16)) u_d0 (
    .clockA(clk), .resetB(rst), .enableA(ena), .writeEnableA(wea), .addressA(adda),
    .dataInA(dina), .dataOutA(oa0), .validA(va0), .enableB(enb), .writeEnableB(web),
    .addressB(addb), .dataInB(dinb), .dataOutB(ob0), .validB(vb0), .collision(co0),
    .collisionCount(cn0));

  block_ram_dual_port_asym_pipe #(.ADDR_WIDTH(4), .B_RATIO_LOG2(1), .WRITE_MODE(1),
    .OUTPUT_REG(1), .CNT_WIDTH(2)) u_d1 (
    .clockA(clk), .resetB(rst), .enableA(ena), .writeEnableA(wea), .addressA(adda),
    .dataInA(dina), .dataOutA(oa1), .validA(va1), .enableB(enb), .writeEnableB(web),
    .addressB(addb), .dataInB(dinb), .dataOutB(ob1), .validB(vb1), .collision(co1),
    .collisionCount(cn1));

  block_ram_dual_port_asym_pipe #(.ADDR_WIDTH(4), .B_RATIO_LOG2(1), .WRITE_MODE(2),
    .OUTPUT_REG(0), .DATA_OUT_RESET_VAL(16'h5A5A), .CNT_WIDTH(16)) u_d2 (
    .clockA(clk), .resetB(rst), .enableA(ena), .writeEnableA(wea), .addressA(adda),
    .dataInA(dina), .dataOutA(oa2), .validA(va2), .enableB(enb), .writeEnableB(web),
    .addressB(addb), .dataInB(dinb), .dataOutB(ob2), .validB(vb2), .collision(co2),
    .collisionCount(cn2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Per-instance characteristics.
  int          mode [3] = '{0, 1, 2};
  int          lat  [3] = '{1, 2, 1};
  int          cmax [3] = '{65535, 3, 65535};
  logic [15:0] rstv [3] = '{16'h0000, 16'h0000, 16'h5A5A};

  // Model state: memory, expected outputs, and a 4-slot timing wheel of
  // pending read results indexed by the cycle they become visible.
  logic [15:0] m [16];
  logic [31:0] e_oa [3];
  logic [31:0] e_ob [3];
  logic        e_va [3];
  logic        e_vb [3];
  logic        e_co [3];
  int          e_cn [3];
  logic        sv [3][2][4];
  logic [31:0] sd [3][2][4];
  int          cyc = 0;

  task automatic sched(input int d, input int p, input int due, input logic [31:0] v);
    sv[d][p][due % 4] = 1'b1;
    sd[d][p][due % 4] = v;
  endtask

  task automatic chk_dut(input int d, input logic [15:0] oa, input logic va,
                         input logic [31:0] ob, input logic vb, input logic co,
                         input logic [15:0] cn);
    chk($sformatf("d%0d dataOutA", d), {16'h0, oa}, e_oa[d]);
    chk($sformatf("d%0d validA", d), {31'h0, va}, {31'h0, e_va[d]});
    chk($sformatf("d%0d dataOutB", d), ob, e_ob[d]);
    chk($sformatf("d%0d validB", d), {31'h0, vb}, {31'h0, e_vb[d]});
    chk($sformatf("d%0d collision", d), {31'h0, co}, {31'h0, e_co[d]});
    chk($sformatf("d%0d collisionCount", d), {16'h0, cn}, 32'(e_cn[d]));
  endtask

  // Predict the effect of the current inputs, advance one clock, compare.
  task automatic step();
    logic [15:0] mn [16];
    logic        wa, wb, cl;
    logic [31:0] va_, vb_;
    int          c;
    c = cyc + 1;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int p = 0; p < 2; p++) for (int s = 0; s < 4; s++) sv[d][p][s] = 1'b0;
        e_oa[d] = {16'h0, rstv[d]};
        e_ob[d] = {rstv[d], rstv[d]};
        e_co[d] = 1'b0;
        e_cn[d] = 0;
      end
    end else begin
      wa = ena && (wea != 2'b00);
      wb = enb && (web != 4'b0000);
      mn = m;
      if (ena) for (int j = 0; j < 2; j++) if (wea[j]) mn[adda][8*j +: 8] = dina[8*j +: 8];
      if (enb) for (int k = 0; k < 2; k++) for (int j = 0; j < 2; j++)
        if (web[2*k+j]) mn[2*addb+k][8*j +: 8] = dinb[16*k+8*j +: 8];
      cl = 1'b0;
      if (wa && wb) for (int k = 0; k < 2; k++)
        if (2*int'(addb)+k == int'(adda) && (wea & web[2*k +: 2]) != 2'b00) cl = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (ena && !(wa && mode[d] == 2)) begin
          va_ = {16'h0, m[adda]};
          if (wa && mode[d] == 1)
            for (int j = 0; j < 2; j++) if (wea[j]) va_[8*j +: 8] = mn[adda][8*j +: 8];
          sched(d, 0, c + lat[d] - 1, va_);
        end
        if (enb && !(wb && mode[d] == 2)) begin
          vb_ = {m[2*addb+1], m[2*addb]};
          if (wb && mode[d] == 1)
            for (int b = 0; b < 4; b++) if (web[b]) vb_[8*b +: 8] = dinb[8*b +: 8];
          sched(d, 1, c + lat[d] - 1, vb_);
        end
        e_co[d] = cl;
        if (cl && e_cn[d] < cmax[d]) e_cn[d]++;
      end
      m = mn;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      e_va[d] = sv[d][0][cyc % 4];
      if (e_va[d]) e_oa[d] = sd[d][0][cyc % 4];
      sv[d][0][cyc % 4] = 1'b0;
      e_vb[d] = sv[d][1][cyc % 4];
      if (e_vb[d]) e_ob[d] = sd[d][1][cyc % 4];
      sv[d][1][cyc % 4] = 1'b0;
    end
    chk_dut(0, oa0, va0, ob0, vb0, co0, cn0);
    chk_dut(1, oa1, va1, ob1, vb1, co1, {14'h0, cn1});
    chk_dut(2, oa2, va2, ob2, vb2, co2, cn2);
  endtask

  task automatic set_a(input logic en, input logic [1:0] we, input logic [3:0] ad,
                       input logic [15:0] di);
    ena = en; wea = we; adda = ad; dina = di;
  endtask

  task automatic set_b(input logic en, input logic [3:0] we, input logic [2:0] ad,
                       input logic [31:0] di);
    enb = en; web = we; addb = ad; dinb = di;
  endtask

  int sat_seq [5] = '{1, 2, 3, 3, 3};

  initial begin
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 2; p++) for (int s = 0; s < 4; s++) sv[d][p][s] = 1'b0;

    // Reset with a write pending: it must not land.
    rst = 1'b1;
    set_a(1'b1, 2'b11, 4'd5, 16'hBEEF);
    set_b(1'b0, 4'b0000, 3'd0, 32'h0);
    step();
    step();
    chk("tp reset validA", {31'h0, va0}, 32'h0);
    chk("tp reset d2 dataOutB", ob2, 32'h5A5A_5A5A);
    rst = 1'b0;
    set_a(1'b1, 2'b00, 4'd5, 16'h0000);
    step();
    chk("tp reset read addr5", {16'h0, oa0}, 32'h0000_0000);
    chk("tp reset read valid", {31'h0, va0}, 32'h1);

    // Asymmetric lane mapping.
    set_a(1'b1, 2'b11, 4'd6, 16'h1111); step();
    set_a(1'b1, 2'b11, 4'd7, 16'h2222); step();
    set_a(1'b0, 2'b00, 4'd0, 16'h0000);
    set_b(1'b1, 4'b0000, 3'd3, 32'h0);
    step();
    chk("tp wide read data", ob0, 32'h2222_1111);
    chk("tp wide read valid", {31'h0, vb0}, 32'h1);
    set_b(1'b0, 4'b0000, 3'd0, 32'h0);

    // Same-port read-during-write modes.
    set_a(1'b1, 2'b11, 4'd4, 16'hAAAA); step();
    set_a(1'b1, 2'b11, 4'd4, 16'h5555); step();
    chk("tp read-first data", {16'h0, oa0}, 32'h0000_AAAA);
    chk("tp no-change valid", {31'h0, va2}, 32'h0);
    set_a(1'b0, 2'b00, 4'd0, 16'h0000); step();
    chk("tp write-first data", {16'h0, oa1}, 32'h0000_5555);

    // Collision: B wins the overlapping byte.
    set_a(1'b1, 2'b11, 4'd8, 16'h1234);
    set_b(1'b1, 4'b0001, 3'd4, 32'h0000_ABCD);
    step();
    chk("tp collision pulse", {31'h0, co0}, 32'h1);
    chk("tp collision count", {16'h0, cn0}, 32'h1);
    set_a(1'b1, 2'b00, 4'd8, 16'h0000);
    set_b(1'b0, 4'b0000, 3'd0, 32'h0);
    step();
    chk("tp collision one-shot", {31'h0, co0}, 32'h0);
    chk("tp collision merged", {16'h0, oa0}, 32'h0000_12CD);
    set_a(1'b1, 2'b10, 4'd8, 16'h7700);
    set_b(1'b1, 4'b0001, 3'd4, 32'h0000_00EE);
    step();
    chk("tp disjoint no collision", {31'h0, co0}, 32'h0);

    // Pipelined reads on the latency-2 instance, interrupted by reset.
    set_b(1'b0, 4'b0000, 3'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      set_a(1'b1, 2'b00, 4'(i), 16'h0000);
      step();
    end
    set_a(1'b0, 2'b00, 4'd0, 16'h0000);
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tp flushed read", {31'h0, va1}, 32'h0);
    end

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 2'b11, 4'd8, 16'(16'h1000 + i));
      set_b(1'b1, 4'b0011, 3'd4, 32'(32'h2000 + i));
      step();
      chk($sformatf("tp saturate %0d", i), {30'h0, cn1}, 32'(sat_seq[i]));
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      ena  = ($urandom_range(0, 3) != 0);
      wea  = $urandom_range(0, 1) ? 2'($urandom) : 2'b00;
      adda = 4'($urandom);
      dina = 16'($urandom);
      enb  = ($urandom_range(0, 3) != 0);
      web  = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
      addb = 3'($urandom);
      dinb = $urandom;
      if ($urandom_range(0, 3) == 0) adda = {addb, 1'($urandom)};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
